// File: rtl/cpc_mem_pkg.sv
// Shared types and page map for the CPC SDRAM scheduler.
// CPC_MEM_SCHED_MF2_EN enables the MF2 ROM page (0x1FF) in the map and the ROM mask.
package cpc_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RUN   = 2'd3
   } mem_sched_state_t;

   typedef struct packed {
      logic [22:0] addr;
      logic        bank;
      logic [7:0]  data;
   } dl_entry_t;

   localparam int DL_ENTRY_W = $bits(dl_entry_t);

   localparam logic [8:0] PAGE_OS     = 9'h000;
   localparam logic [8:0] PAGE_BASIC  = 9'h100;
   localparam logic [8:0] PAGE_AMSDOS = 9'h107;
   localparam logic [8:0] PAGE_MF2    = 9'h1FF;

   typedef struct packed {
      logic       mapped;
      logic       bank;
      logic [8:0] base;
   } page_info_t;

   // Download page -> SDRAM 16 KB block; only pages 0..7 are ever stored.
   function automatic page_info_t page_map(input logic [10:0] page);
      page_info_t r;
      r.mapped = (page[10:3] == 8'd0);
      r.bank   = page[2];
      case (page[1:0])
         2'd0:    r.base = PAGE_OS;
         2'd1:    r.base = PAGE_BASIC;
         2'd2:    r.base = PAGE_AMSDOS;
         default: begin
            r.base = PAGE_MF2;
`ifndef CPC_MEM_SCHED_MF2_EN
            r.mapped = 1'b0;
`endif
         end
      endcase
      return r;
   endfunction

   // True for CPU blocks backed by RAM or a loaded ROM.
   function automatic logic rom_mapped(input logic [8:0] blk);
      logic m;
      m = (blk[8] == 1'b0) || (blk == PAGE_BASIC) || (blk == PAGE_AMSDOS);
`ifdef CPC_MEM_SCHED_MF2_EN
      m = m || (blk == PAGE_MF2);
`endif
      return m;
   endfunction

endpackage

// File: rtl/cpc_dl_fifo.sv
// Synchronous FIFO for download bytes; exposes occupancy now and after this cycle.
module cpc_dl_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic [CW-1:0]    count_nxt,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)
         count_nxt = count + CW'(1);
      else if (pop_ok && !push_ok)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk_sys) begin
      if (push_ok)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/cpc_mem_sched.sv
// SDRAM port scheduler: ROM download writes while the machine is held in reset, CPU access in RUN.
// CPC_MEM_SCHED_MF2_EN enables the MF2 ROM page.
module cpc_mem_sched #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce_ref,
   input  logic        ext_reset,
   input  logic        model_sel,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [24:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        dl_wait,
   output logic        dl_overflow,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [22:0] cpu_a,
   input  logic [7:0]  cpu_dout,
   output logic        sys_reset,
   output logic        model,
   output logic [7:0]  rom_mask,
   output logic        sd_oe,
   output logic        sd_we,
   output logic [22:0] sd_addr,
   output logic [1:0]  sd_bank,
   output logic [7:0]  sd_din,
   output logic [1:0]  state_dbg
);
   import cpc_mem_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   mem_sched_state_t      state;
   page_info_t            pinfo;
   dl_entry_t             push_entry;
   dl_entry_t             pop_entry;
   logic [DL_ENTRY_W-1:0] fifo_dout;
   logic [CW-1:0]         fifo_count;
   logic [CW-1:0]         fifo_count_nxt;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push_req;
   logic                  pop_req;
   logic                  boot_owner;
   logic                  boot_we;
   logic [22:0]           boot_addr;
   logic                  boot_bank;
   logic [7:0]            boot_din;

   assign pinfo      = page_map(dl_addr[24:14]);
   assign push_req   = dl_wr & dl_active & pinfo.mapped;
   assign push_entry = '{addr: {pinfo.base, dl_addr[13:0]}, bank: pinfo.bank, data: dl_data};
   assign pop_entry  = dl_entry_t'(fifo_dout);
   assign boot_owner = (state == ST_LOAD) || (state == ST_DRAIN);
   assign pop_req    = ce_ref & boot_owner & ~fifo_empty;
   assign state_dbg  = state;

   cpc_dl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DL_ENTRY_W)
   ) u_fifo (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .push      (push_req),
      .din       (push_entry),
      .pop       (pop_req),
      .dout      (fifo_dout),
      .count     (fifo_count),
      .count_nxt (fifo_count_nxt),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state       <= ST_IDLE;
         boot_we     <= 1'b0;
         boot_addr   <= '0;
         boot_bank   <= 1'b0;
         boot_din    <= '0;
         sys_reset   <= 1'b1;
         model       <= 1'b0;
         dl_wait     <= 1'b0;
         dl_overflow <= 1'b0;
      end else begin
         dl_wait   <= (fifo_count_nxt >= CW'(FIFO_DEPTH - 1));
         sys_reset <= ext_reset | (state != ST_RUN);
         if (push_req && fifo_full)
            dl_overflow <= 1'b1;
         if (sys_reset)
            model <= model_sel;

         // The popped entry stays on the bus for the whole slot that follows.
         if (pop_req) begin
            boot_we   <= 1'b1;
            boot_addr <= pop_entry.addr;
            boot_bank <= pop_entry.bank;
            boot_din  <= pop_entry.data;
         end else if (ce_ref) begin
            boot_we <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (dl_active)
                  state <= ST_LOAD;
               else if (ce_ref)
                  state <= ST_RUN;
            end
            ST_LOAD: begin
               if (ce_ref && !dl_active)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (ce_ref && fifo_count == '0)
                  state <= ST_IDLE;
            end
            ST_RUN: begin
               if (ce_ref && dl_active)
                  state <= ST_LOAD;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      sd_oe   = 1'b0;
      sd_we   = 1'b0;
      sd_addr = boot_addr;
      sd_bank = {1'b0, boot_bank};
      sd_din  = boot_din;
      case (state)
         ST_RUN: begin
            sd_oe   = cpu_rd & ~ext_reset;
            sd_we   = cpu_wr & ~ext_reset;
            sd_addr = cpu_a;
            sd_bank = {1'b0, model};
            sd_din  = cpu_dout;
         end
         ST_LOAD, ST_DRAIN: sd_we = boot_we;
         default: ;
      endcase
   end

   assign rom_mask = rom_mapped(cpu_a[22:14]) ? 8'h00 : 8'hFF;

endmodule

// File: tb/tb_cpc_mem_sched.sv
// Directed bench for cpc_mem_sched: download path, page map, backpressure, model latch, ROM mask.
module tb_cpc_mem_sched;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ce_ref = 1'b0;
   logic        ext_reset = 1'b0;
   logic        model_sel = 1'b0;
   logic        dl_active = 1'b0;
   logic        dl_wr = 1'b0;
   logic [24:0] dl_addr = '0;
   logic [7:0]  dl_data = '0;
   logic        dl_wait;
   logic        dl_overflow;
   logic        cpu_rd = 1'b0;
   logic        cpu_wr = 1'b0;
   logic [22:0] cpu_a = '0;
   logic [7:0]  cpu_dout = '0;
   logic        sys_reset;
   logic        model;
   logic [7:0]  rom_mask;
   logic        sd_oe;
   logic        sd_we;
   logic [22:0] sd_addr;
   logic [1:0]  sd_bank;
   logic [7:0]  sd_din;
   logic [1:0]  state_dbg;

   cpc_mem_sched #(.FIFO_DEPTH(4)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ce_ref      (ce_ref),
      .ext_reset   (ext_reset),
      .model_sel   (model_sel),
      .dl_active   (dl_active),
      .dl_wr       (dl_wr),
      .dl_addr     (dl_addr),
      .dl_data     (dl_data),
      .dl_wait     (dl_wait),
      .dl_overflow (dl_overflow),
      .cpu_rd      (cpu_rd),
      .cpu_wr      (cpu_wr),
      .cpu_a       (cpu_a),
      .cpu_dout    (cpu_dout),
      .sys_reset   (sys_reset),
      .model       (model),
      .rom_mask    (rom_mask),
      .sd_oe       (sd_oe),
      .sd_we       (sd_we),
      .sd_addr     (sd_addr),
      .sd_bank     (sd_bank),
      .sd_din      (sd_din),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   always #5 clk_sys = ~clk_sys;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // scoreboard
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   logic        saw_wait = 1'b0;
   logic [32:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; a slot strobe plus sd_we while the machine is held is one download write.
   task automatic step();
      @(posedge clk_sys);
      #1;
      if (ce_ref && sd_we && sys_reset) begin
         wr_cnt++;
         if (exp_q.size() == 0)
            check("wr_extra", 1, 0);
         else
            check("wr_data", {sd_addr, sd_bank, sd_din}, exp_q.pop_front());
         check("wr_oe", sd_oe, 0);
      end
      cyc++;
      ce_ref = ((cyc % 16) == 0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++)
         step();
   endtask

   // driver tasks
   task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
      dl_addr = a;
      dl_data = d;
      dl_wr   = 1'b1;
      step();
      dl_wr   = 1'b0;
   endtask

   task automatic dl_byte_honour(input logic [24:0] a, input logic [7:0] d);
      int n = 0;
      while (dl_wait && n < 200) begin
         saw_wait = 1'b1;
         step();
         n++;
      end
      if (n >= 200)
         check("wait_timeout", 1, 0);
      dl_byte(a, d);
   endtask

   task automatic wait_release(input string tag, input int bound);
      int n = 0;
      while (sys_reset && n < bound) begin
         step();
         n++;
      end
      check(tag, sys_reset, 0);
   endtask

   task automatic mask_case(input logic [8:0] blk, input logic [7:0] exp);
      cpu_a = {blk, 14'h0};
      #1;
      check("rom_mask", rom_mask, exp);
   endtask

   initial begin
      int base;
      // reset state
      steps(3);
      check("rst_sys_reset", sys_reset, 1);
      check("rst_model", model, 0);
      check("rst_dl_wait", dl_wait, 0);
      check("rst_overflow", dl_overflow, 0);
      check("rst_oe", sd_oe, 0);
      check("rst_we", sd_we, 0);
      check("rst_addr", sd_addr, 0);
      check("rst_bank", sd_bank, 0);
      check("rst_din", sd_din, 0);
      check("rst_state", state_dbg, 0);

      // single byte
      dl_active = 1'b1;
      reset = 1'b0;
      step();
      dl_byte(25'h0000123, 8'h5A);
      exp_q.push_back({23'h000123, 2'b00, 8'h5A});
      steps(40);
      check("single_done", exp_q.size(), 0);
      dl_active = 1'b0;
      wait_release("single_release", 50);

      // page map
      dl_active = 1'b1;
      dl_byte_honour(25'h0004123, 8'h11);
      exp_q.push_back({23'h400123, 2'b00, 8'h11});
      dl_byte_honour(25'h0018055, 8'h22);
      exp_q.push_back({23'h41C055, 2'b01, 8'h22});
      dl_byte_honour(25'h001C0AA, 8'h33);
`ifdef CPC_MEM_SCHED_MF2_EN
      exp_q.push_back({23'h7FC0AA, 2'b01, 8'h33});
`endif
      dl_byte_honour(25'h0024000, 8'h44);
      steps(100);
      dl_active = 1'b0;
      wait_release("pages_release", 300);
      check("pages_done", exp_q.size(), 0);

      // backpressure honoured
      dl_active = 1'b1;
      saw_wait = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dl_byte_honour(25'(i), 8'hA0 + 8'(i));
         exp_q.push_back({23'(i), 2'b00, 8'hA0 + 8'(i)});
      end
      check("bp_saw_wait", saw_wait, 1);
      dl_active = 1'b0;
      wait_release("bp_release", 400);
      check("bp_done", exp_q.size(), 0);
      check("bp_overflow", dl_overflow, 0);

      // backpressure ignored: burst starts just after a slot strobe
      dl_active = 1'b1;
      for (int n = 0; n < 20 && !ce_ref; n++)
         step();
      step();
      for (int i = 0; i < 8; i++) begin
         dl_byte(25'h0000100 + 25'(i), 8'hC0 + 8'(i));
         if (i < 4)
            exp_q.push_back({23'h000100 + 23'(i), 2'b00, 8'hC0 + 8'(i)});
      end
      check("ovf_set", dl_overflow, 1);
      dl_active = 1'b0;
      wait_release("ovf_release", 300);
      check("ovf_done", exp_q.size(), 0);
      check("ovf_sticky", dl_overflow, 1);
      reset = 1'b1;
      steps(2);
      reset = 1'b0;
      check("ovf_cleared", dl_overflow, 0);
      wait_release("ovf_rst_release", 40);

      // model latch
      ext_reset = 1'b1;
      model_sel = 1'b1;
      cpu_rd = 1'b1;
      cpu_wr = 1'b1;
      steps(3);
      check("ext_sys_reset", sys_reset, 1);
      check("ext_oe_gated", sd_oe, 0);
      check("ext_we_gated", sd_we, 0);
      cpu_wr = 1'b0;
      ext_reset = 1'b0;
      step();
      model_sel = 1'b0;
      cpu_a = 23'h004000;
      step();
      check("run_sys_reset", sys_reset, 0);
      check("model_latched", model, 1);
      check("run_oe", sd_oe, 1);
      check("run_we", sd_we, 0);
      check("run_bank", sd_bank, 2'b01);
      check("run_addr", sd_addr, 23'h004000);
      cpu_rd = 1'b0;
      cpu_wr = 1'b1;
      cpu_dout = 8'h3C;
      step();
      check("run_wr_we", sd_we, 1);
      check("run_wr_din", sd_din, 8'h3C);
      check("model_hold", model, 1);
      cpu_wr = 1'b0;

      // reset mid-load
      dl_active = 1'b1;
      base = wr_cnt;
      for (int i = 0; i < 4; i++) begin
         dl_byte_honour(25'h0000200 + 25'(i), 8'h10 + 8'(i));
         exp_q.push_back({23'h000200 + 23'(i), 2'b00, 8'h10 + 8'(i)});
      end
      for (int n = 0; n < 200 && wr_cnt < base + 2; n++)
         step();
      check("mid_two_written", wr_cnt - base, 2);
      reset = 1'b1;
      step();
      check("mid_we_drop", sd_we, 0);
      check("mid_sys_reset", sys_reset, 1);
      check("mid_dl_wait", dl_wait, 0);
      exp_q.delete();
      reset = 1'b0;
      steps(64);
      check("mid_no_more_wr", wr_cnt - base, 2);
      dl_active = 1'b0;
      wait_release("mid_release", 80);

      // ROM mask
      mask_case(9'h107, 8'h00);
      mask_case(9'h150, 8'hFF);
      mask_case(9'h0FF, 8'h00);
      mask_case(9'h100, 8'h00);
      mask_case(9'h101, 8'hFF);
`ifdef CPC_MEM_SCHED_MF2_EN
      mask_case(9'h1FF, 8'h00);
`else
      mask_case(9'h1FF, 8'hFF);
`endif

      // report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
